// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, GF(2^8) helpers and the key-schedule step.
// Imported by the iterative encryptor and its one-round datapath.
package aes_pkg;

  // [column][row]; element [0][0] sits in the MSBs, matching FIPS byte order
  typedef logic [0:3][0:3][7:0] state_t;

  typedef enum logic [1:0] {
    IDLE,
    KEYX,
    ROUND
  } fsm_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xtime(
    input logic [7:0] a
  );
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox(
    input logic [7:0] a
  );
    logic [7:0] e;
    logic [7:0] p;
    logic [7:0] r;
    e = 8'hfe;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
             ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(
    input logic [31:0] w
  );
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // pos is i mod Nk; rc is the Rcon byte for the current key block
  function automatic logic [31:0] key_word_next(
    input logic [31:0] prev,
    input logic [31:0] back,
    input logic [2:0]  pos,
    input logic [7:0]  rc,
    input int          nk
  );
    logic [31:0] t;
    t = prev;
    if (pos == 3'd0)
      t = sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0};
    else if (nk == 8 && pos == 3'd4)
      t = sub_word(prev);
    return t ^ back;
  endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// aes_encrypt_iter_if: key, plaintext and ciphertext handshakes.
// master drives requests; slave is the encryptor side.
interface aes_encrypt_iter_if #(
  parameter int Nk = 4
);

  logic              key_load;
  logic              key_ready;
  logic [32*Nk-1:0]  key;
  logic              key_valid;
  logic              pt_valid;
  logic              pt_ready;
  logic [127:0]      pt;
  logic              ct_valid;
  logic              ct_ready;
  logic [127:0]      ct;

  modport master (
    output key_load, key, pt_valid, pt, ct_ready,
    input  key_ready, key_valid, pt_ready, ct_valid, ct
  );

  modport slave (
    input  key_load, key, pt_valid, pt, ct_ready,
    output key_ready, key_valid, pt_ready, ct_valid, ct
  );

endinterface

// File: rtl/aes_enc_round.sv
// aes_enc_round: combinational AES round (SubBytes, ShiftRows,
// MixColumns, AddRoundKey); last_round bypasses MixColumns.
module aes_enc_round
  import aes_pkg::*;
(
  input  state_t       st,
  input  logic [127:0] rk,
  input  logic         last_round,
  output state_t       res
);

  state_t sr;
  state_t mc;

  always_comb begin
    sr = '0;
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[c][r] = sbox(st[(c + r) % 4][r]);
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[c][0] = xtime(sr[c][0]) ^ xtime(sr[c][1])
               ^ sr[c][1] ^ sr[c][2] ^ sr[c][3];
      mc[c][1] = sr[c][0] ^ xtime(sr[c][1])
               ^ xtime(sr[c][2]) ^ sr[c][2] ^ sr[c][3];
      mc[c][2] = sr[c][0] ^ sr[c][1] ^ xtime(sr[c][2])
               ^ xtime(sr[c][3]) ^ sr[c][3];
      mc[c][3] = xtime(sr[c][0]) ^ sr[c][0] ^ sr[c][1]
               ^ sr[c][2] ^ xtime(sr[c][3]);
    end
    res = (last_round ? sr : mc) ^ rk;
  end

endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES encryptor, one round per clock.
// Build option AES_ENC_ZEROIZE_EN scrubs ct/state after delivery.
module aes_encrypt_iter
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input logic clk,
  input logic rst,
  aes_encrypt_iter_if.slave bus
);

  localparam int Nr = Nk + 6;
  localparam int NW = 4 * (Nr + 1);
  localparam logic [5:0] NK_W   = 6'(Nk);
  localparam logic [5:0] LAST_W = 6'(NW - 1);
  localparam logic [3:0] NR_R   = 4'(Nr);
  localparam logic [2:0] NK_P   = 3'(Nk - 1);

  fsm_e         fsm;
  fsm_e         fsm_nx;
  logic [31:0]  w [NW];
  logic [5:0]   idx;
  logic [5:0]   rb;
  logic [2:0]   pos;
  logic [3:0]   rci;
  logic [3:0]   rnd;
  logic         key_v;
  logic         ct_v;
  logic [127:0] ct_q;
  logic [127:0] rk;
  logic [31:0]  w_new;
  state_t       st;
  state_t       res;
  logic         idle;
  logic         pt_rdy;
  logic         key_acc;
  logic         pt_acc;
  logic         ct_acc;
  logic         last_w;
  logic         last_r;

  assign idle    = fsm == IDLE;
  // a pending key load masks plaintext acceptance in the same cycle
  assign pt_rdy  = idle && key_v && !ct_v && !bus.key_load;
  assign key_acc = idle && bus.key_load;
  assign pt_acc  = pt_rdy && bus.pt_valid;
  assign ct_acc  = ct_v && bus.ct_ready;
  assign last_w  = idx == LAST_W;
  assign last_r  = rnd == NR_R;

  assign rb    = (fsm == ROUND) ? {rnd, 2'b00} : 6'd0;
  assign rk    = {w[rb], w[rb + 6'd1], w[rb + 6'd2], w[rb + 6'd3]};
  assign w_new = key_word_next(w[idx - 6'd1], w[idx - NK_W],
                               pos, RCON[rci], Nk);

  assign bus.key_ready = idle;
  assign bus.key_valid = key_v;
  assign bus.pt_ready  = pt_rdy;
  assign bus.ct_valid  = ct_v;
`ifdef AES_ENC_ZEROIZE_EN
  assign bus.ct = ct_v ? ct_q : '0;
`else
  assign bus.ct = ct_q;
`endif

  aes_enc_round u_round (
    .st         (st),
    .rk         (rk),
    .last_round (last_r),
    .res        (res)
  );

  always_ff @(posedge clk) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nx;
  end

  always_comb begin
    fsm_nx = fsm;
    unique case (fsm)
      IDLE: begin
        if (key_acc)     fsm_nx = KEYX;
        else if (pt_acc) fsm_nx = ROUND;
      end
      KEYX:    if (last_w) fsm_nx = IDLE;
      ROUND:   if (last_r) fsm_nx = IDLE;
      default: fsm_nx = IDLE;
    endcase
  end

  // schedule contents carry no reset; key_valid guards their use
  always_ff @(posedge clk) begin
    if (key_acc) begin
      for (int j = 0; j < Nk; j++)
        w[j] <= bus.key[32*(Nk-1-j) +: 32];
    end else if (fsm == KEYX) begin
      w[idx] <= w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_v <= 1'b0;
      ct_v  <= 1'b0;
      ct_q  <= '0;
      rnd   <= 4'd0;
      idx   <= 6'd0;
      pos   <= 3'd0;
      rci   <= 4'd0;
      st    <= '0;
    end else begin
      if (ct_acc) ct_v <= 1'b0;
      unique case (fsm)
        IDLE: begin
          if (key_acc) begin
            idx   <= NK_W;
            pos   <= 3'd0;
            rci   <= 4'd0;
            key_v <= 1'b0;
          end else if (pt_acc) begin
            st  <= bus.pt ^ rk;
            rnd <= 4'd1;
          end
        end
        KEYX: begin
          idx <= idx + 6'd1;
          pos <= (pos == NK_P) ? 3'd0 : pos + 3'd1;
          if (pos == 3'd0) rci <= rci + 4'd1;
          if (last_w) key_v <= 1'b1;
        end
        ROUND: begin
          if (last_r) begin
            ct_q <= res;
            ct_v <= 1'b1;
          end else begin
            st  <= res;
            rnd <= rnd + 4'd1;
          end
        end
        default: ;
      endcase
`ifdef AES_ENC_ZEROIZE_EN
      if (ct_acc || key_acc) st <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: known-answer, handshake, reset and random tests
// for Nk=4/6/8 against a byte-level reference cipher.
module tb_aes_encrypt_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [2:0]          key_load;
  logic [2:0]          pt_valid;
  logic [2:0]          ct_ready;
  logic [2:0][255:0]   key_in;
  logic [2:0][127:0]   pt_in;
  wire  [2:0]          key_ready;
  wire  [2:0]          key_valid;
  wire  [2:0]          pt_ready;
  wire  [2:0]          ct_valid;
  wire  [2:0][127:0]   ct;

  int         n_chk;
  int         n_err;
  int         lg [256];
  logic [7:0] ex [256];
  logic [7:0] sb [256];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int K = 4 + 2 * g;
    aes_encrypt_iter_if #(.Nk(K)) bus ();
    aes_encrypt_iter #(.Nk(K)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign bus.key_load = key_load[g];
    assign bus.key      = key_in[g][255 -: 32*K];
    assign bus.pt_valid = pt_valid[g];
    assign bus.pt       = pt_in[g];
    assign bus.ct_ready = ct_ready[g];
    assign key_ready[g] = bus.key_ready;
    assign key_valid[g] = bus.key_valid;
    assign pt_ready[g]  = bus.pt_ready;
    assign ct_valid[g]  = bus.ct_valid;
    assign ct[g]        = bus.ct;
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return ex[(lg[a] + lg[b]) % 255];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [255:0] k,
                                           input int nk,
                                           input logic [127:0] p);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  x;
    logic [7:0]   rc;
    logic [127:0] o;
    int           nr;
    nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      x = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / nk; j++) rc = gm(rc, 8'h02);
        x = subw({x[23:0], x[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        x = subw(x);
      end
      w[i] = w[i-nk] ^ x;
    end
    for (int b = 0; b < 16; b++)
      s[b] = p[127 - 8*b -: 8] ^ w[b/4][31 - 8*(b%4) -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int b = 0; b < 16; b++)
        t[b] = sb[s[b%4 + 4*((b/4 + b%4) % 4)]];
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (rd == nr) s[r+4*c] = t[r+4*c];
          else s[r+4*c] = gm(8'h02, t[r+4*c])
                        ^ gm(8'h03, t[(r+1)%4 + 4*c])
                        ^ t[(r+2)%4 + 4*c] ^ t[(r+3)%4 + 4*c];
        end
      end
      for (int b = 0; b < 16; b++)
        s[b] = s[b] ^ w[4*rd + b/4][31 - 8*(b%4) -: 8];
    end
    for (int b = 0; b < 16; b++) o[127 - 8*b -: 8] = s[b];
    return o;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int j = 0; j < 8; j++) r[32*j +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [255:0] r;
    r = rnd256();
    return r[127:0];
  endfunction

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int u);
    chk("rst_flags", {key_ready[u], key_valid[u], pt_ready[u],
                      ct_valid[u]}, 4'b1000);
    chk("rst_ct", ct[u], 0);
  endtask

  task automatic start_key(input int u, input logic [255:0] k);
    key_load[u] = 1'b1;
    key_in[u]   = k;
    tick();
    key_load[u] = 1'b0;
    key_in[u]   = rnd256();
  endtask

  task automatic load_key(input int u, input logic [255:0] k);
    int n;
    int nk;
    nk = 4 + 2 * u;
    start_key(u, k);
    chk("kx_busy", {key_ready[u], key_valid[u]}, 0);
    n = 0;
    while (!key_valid[u] && n < 100) begin
      tick();
      n++;
    end
    chk("kx_cycles", n, 4 * (nk + 7) - nk);
  endtask

  task automatic send_pt(input int u, input logic [127:0] p);
    int n;
    pt_valid[u] = 1'b1;
    pt_in[u]    = p;
    n = 0;
    while (!pt_ready[u] && n < 100) begin
      tick();
      n++;
    end
    chk("pt_accept", pt_ready[u], 1);
    tick();
    pt_valid[u] = 1'b0;
    pt_in[u]    = rnd128();
  endtask

  task automatic wait_ct(input int u, input logic [127:0] e);
    int n;
    n = 0;
    while (!ct_valid[u] && n < 100) begin
      tick();
      n++;
    end
    chk("ct_latency", n + 1, 4 + 2 * u + 7);
    chk("ct_value", ct[u], e);
  endtask

  task automatic take_ct(input int u, input logic [127:0] e);
    ct_ready[u] = 1'b1;
    tick();
    ct_ready[u] = 1'b0;
    chk("ct_drop", ct_valid[u], 0);
    chk("pt_ready_next", pt_ready[u], 1);
`ifdef AES_ENC_ZEROIZE_EN
    chk("ct_zero", ct[u], 0);
`else
    chk("ct_hold", ct[u], e);
`endif
  endtask

  initial begin
    logic [7:0]   p;
    logic [7:0]   v;
    logic [7:0]   s;
    logic [15:0]  d;
    logic [255:0] k;
    logic [127:0] q;
    logic [127:0] e;
    int           n;
    int           u;

    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      ex[i] = p;
      lg[p] = i;
      p = p ^ xt(p);
    end
    ex[255] = 8'h01;
    for (int i = 0; i < 256; i++) begin
      v = (i == 0) ? 8'h00 : ex[(255 - lg[i]) % 255];
      d = {v, v};
      s = v ^ 8'h63;
      for (int j = 1; j <= 4; j++) s = s ^ 8'(d >> (8 - j));
      sb[i] = s;
    end

    n_chk    = 0;
    n_err    = 0;
    rst      = 1'b1;
    key_load = '0;
    pt_valid = '0;
    ct_ready = '0;
    key_in   = '0;
    pt_in    = '0;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) chk_reset(i);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) chk_reset(i);

    k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    q = 128'h00112233445566778899aabbccddeeff;
    e = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    chk("model_kat", ref_enc(k, 4, q), e);
    load_key(0, k);
    send_pt(0, q);
    wait_ct(0, e);
    take_ct(0, e);

    k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
    e = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    load_key(1, k);
    send_pt(1, q);
    wait_ct(1, e);
    take_ct(1, e);

    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    e = 128'h8ea2b7ca516745bfeafc49904b496089;
    load_key(2, k);
    send_pt(2, q);
    wait_ct(2, e);
    take_ct(2, e);

    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    e = 128'h3925841d02dc09fbdc118597196a0b32;
    load_key(0, k);
    send_pt(0, 128'h3243f6a8885a308d313198a2e0370734);
    wait_ct(0, e);
    q = rnd128();
    pt_valid[0] = 1'b1;
    pt_in[0]    = q;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_pt_ready", pt_ready[0], 0);
      chk("bp_ct", {ct_valid[0], ct[0][126:0]}, {1'b1, e[126:0]});
    end
    take_ct(0, e);
    send_pt(0, q);
    e = ref_enc(k, 4, q);
    wait_ct(0, e);

    load_key(0, rnd256());
    chk("reload_ct", ct[0], e);
    chk("reload_ctv", ct_valid[0], 1);
    take_ct(0, e);

    k = rnd256();
    q = rnd128();
    key_load[0] = 1'b1;
    key_in[0]   = k;
    pt_valid[0] = 1'b1;
    pt_in[0]    = q;
    #1;
    chk("sim_pt_ready", pt_ready[0], 0);
    tick();
    key_load[0] = 1'b0;
    key_in[0]   = rnd256();
    n = 0;
    while (!key_valid[0] && n < 100) begin
      chk("sim_no_accept", pt_ready[0], 0);
      tick();
      n++;
    end
    chk("sim_kx_cycles", n, 40);
    send_pt(0, q);
    e = ref_enc(k, 4, q);
    wait_ct(0, e);
    take_ct(0, e);

    for (int it = 0; it < 6; it++) begin
      u = $urandom_range(0, 2);
      k = rnd256();
      q = rnd128();
      e = ref_enc(k, 4 + 2 * u, q);
      load_key(u, k);
      send_pt(u, q);
      wait_ct(u, e);
      repeat ($urandom_range(0, 3)) tick();
      take_ct(u, e);
    end

    load_key(0, rnd256());
    send_pt(0, rnd128());
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk_reset(0);
    rst = 1'b0;
    n = 0;
    repeat (20) begin
      tick();
      if (ct_valid[0] || key_valid[0]) n++;
    end
    chk("round_abort", n, 0);

    start_key(0, rnd256());
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk_reset(0);
    rst = 1'b0;
    n = 0;
    repeat (60) begin
      tick();
      if (ct_valid[0] || key_valid[0]) n++;
    end
    chk("keyx_abort", n, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_iter.md
Name: aes_encrypt_iter

Overview:
- Iterative, area-oriented AES encryptor (FIPS-197) for Nk=4/6/8.
- Transmit-side counterpart to the fully pipelined decryptor: one round per clock, one block in flight.
- Loads a cipher key and expands it serially into an internal round-key register file, one word per cycle.
- Accepts plaintext and returns ciphertext over ready/valid handshakes.

Parameters:
- Nk, 4, key length in 32-bit words (4, 6 or 8).
- Nr, Nk+6, number of rounds (derived; not overridden).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- key_load  input  1  key handshake valid.
- key_ready  output  1  key handshake ready.
- key  input  32*Nk  cipher key; word 0 in the MSBs (FIPS byte order).
- key_valid  output  1  a complete expanded key schedule is held.
- pt_valid  input  1  plaintext handshake valid.
- pt_ready  output  1  plaintext handshake ready.
- pt  input  128  plaintext block.
- ct_valid  output  1  ciphertext handshake valid.
- ct_ready  input  1  ciphertext handshake ready.
- ct  output  128  ciphertext block.

Behaviour:
- Reset: FSM=IDLE, key_valid=0, ct_valid=0, ct=0, round counter=0, word index=0. Schedule contents are don't-care.
- FSM states: IDLE, KEYX, ROUND.
- key_ready = (FSM==IDLE).
- pt_ready = (FSM==IDLE) && key_valid && !ct_valid && !key_load.
  - key_load has priority; the combinational path from key_load is intentional.
- Key load, IDLE -> KEYX:
  - On key_load&&key_ready: write w[0..Nk-1] from key, set word index i=Nk, clear key_valid.
- KEYX:
  - Each cycle compute w[i] per FIPS-197 (RotWord/SubWord/Rcon when i%Nk==0; SubWord only when Nk==8 && i%Nk==4), then i++.
  - Stay in KEYX for 4*(Nr+1)-Nk cycles: 40 / 46 / 52.
  - After the last word: key_valid=1, FSM -> IDLE.
- Key reload while ct_valid=1 is permitted. The pending ct is unaffected.
- Encrypt, IDLE -> ROUND:
  - On pt_valid&&pt_ready (cycle T): state <= pt ^ rk[0], round r=1.
- ROUND:
  - Each cycle apply SubBytes, ShiftRows, MixColumns, then AddRoundKey rk[r]. MixColumns is skipped when r==Nr.
  - When r==Nr: ct <= result, ct_valid <= 1, FSM -> IDLE.
  - ct_valid rises in cycle T+Nr+1.
- Output: ct and ct_valid hold until ct_valid&&ct_ready; then ct_valid=0 next cycle.
- Max throughput: one block per Nr+2 cycles.
- Inputs are ignored outside their handshake: pt/key may change freely when not accepted.
- rst asserted in KEYX or ROUND: abort, return to reset values. key_valid=0, so a fresh key load is required.
- Round counter width: 4 bits. Key word index width: 6 bits. No wrap occurs within legal Nk.

Optional Feature:
- Macro: AES_ENC_ZEROIZE_EN.
- Defined:
  - ct is forced to 0 whenever ct_valid=0.
  - The internal state register is cleared to 0 in the cycle after a ct handshake and on every KEYX entry.
  - No plaintext-derived data persists after delivery.
- Undefined: ct holds the last ciphertext after the handshake; the state register is left as is.

Decomposition:
- Package aes_pkg:
  - state typedef (4x4 byte array).
  - S-box function, xtime, Rcon constant array.
  - FSM enum (IDLE/KEYX/ROUND).
  - Key-word next function shared with the existing key-expansion logic.
- Sub-module aes_enc_round: combinational one-round datapath with a last_round input that bypasses MixColumns. It is instantiated once.

Test Plan:
- Nk=4: load key 000102030405060708090a0b0c0d0e0f.
  - key_valid rises after 40 KEYX cycles.
  - pt 00112233445566778899aabbccddeeff -> ct 69c4e0d86a7b0430d8cdb78070b4c55a, with ct_valid at T+11.
- Nk=6: key 000102..1617, same pt -> ct dda97ca4864cdfe06eaf70a0ec0d7191; 46 KEYX cycles, ct_valid at T+13.
- Nk=8: key 000102..1e1f, same pt -> ct 8ea2b7ca516745bfeafc49904b496089; 52 KEYX cycles, ct_valid at T+15.
- Backpressure:
  - Hold ct_ready=0 for 20 cycles with pt_valid=1. Required: pt_ready=0 throughout and ct stable.
  - Release ct_ready. The next pt is accepted 1 cycle after the handshake.
  - Key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
- Simultaneous key_load and pt_valid in IDLE: key wins, pt_ready=0, and the pt is encrypted correctly under the new key after KEYX.
- rst pulsed mid-ROUND and mid-KEYX: next cycle all outputs are at reset values, key_valid=0, and no ct_valid pulse occurs.
- With AES_ENC_ZEROIZE_EN: ct==0 one cycle after the handshake.
